// File: rtl/vip_sobel_ctrl.sv
// rtl/vip_sobel_ctrl.sv - Sobel frame controller: coordinate tracking, border mask, shadowed threshold, geometry status.
// Optional edge statistics counter enabled by defining VIP_SOBEL_CTRL_STATS_EN.
module vip_sobel_ctrl #(
  parameter int BITS   = 8,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            cfg_en,
  input  logic [BITS-1:0] cfg_thresh,
  input  logic            cfg_binary,
  input  logic            cfg_apply,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_data,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_data,
  output logic            frame_done,
  output logic [15:0]     frame_cnt,
  output logic            err_geom,
  output logic [31:0]     edge_cnt
);

  localparam logic [15:0] WIDTH_L  = 16'(WIDTH);
  localparam logic [15:0] HEIGHT_L = 16'(HEIGHT);

  typedef enum logic [1:0] {
    WAIT_VS,
    FRAME,
    LINE
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     x, y, x_nxt, y_nxt;
  logic [15:0]     x_inc, y_inc, x_end;
  logic            vs_prev, href_prev;
  logic            vs_rise, vs_fall, href_rise;
  logic            err_set, frame_end;

  logic            sh_en, sh_binary;
  logic [BITS-1:0] sh_thresh;
  logic            stg_en, stg_binary;
  logic [BITS-1:0] stg_thresh;
  logic            pending;

  logic            tracked, border, hit;
  logic [15:0]     px;
  logic [BITS-1:0] proc_data;

  // vs_prev resets high so a frame already in progress at reset is not seen as a rise
  assign vs_rise   = in_vsync & ~vs_prev;
  assign vs_fall   = ~in_vsync & vs_prev;
  assign href_rise = in_href & ~href_prev;
  assign x_inc     = (x == 16'hFFFF) ? x : x + 16'd1;
  assign y_inc     = (y == 16'hFFFF) ? y : y + 16'd1;

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    x_end     = x;
    err_set   = 1'b0;
    frame_end = 1'b0;
    case (state)
      WAIT_VS: begin
        if (vs_rise) begin
          state_nxt = FRAME;
          y_nxt     = 16'd0;
        end
      end
      FRAME: begin
        if (vs_fall) begin
          frame_end = 1'b1;
          err_set   = (y != HEIGHT_L);
          state_nxt = WAIT_VS;
        end else if (href_rise) begin
          // the rise cycle carries pixel 0, so the count already includes it
          state_nxt = LINE;
          x_nxt     = 16'd1;
        end
      end
      LINE: begin
        x_end = in_href ? x_inc : x;
        if (in_href) x_nxt = x_inc;
        if (vs_fall) begin
          frame_end = 1'b1;
          err_set   = (x_end != WIDTH_L) || (y_inc != HEIGHT_L);
          y_nxt     = y_inc;
          state_nxt = WAIT_VS;
        end else if (!in_href) begin
          err_set   = (x != WIDTH_L);
          y_nxt     = y_inc;
          state_nxt = FRAME;
        end
      end
      default: state_nxt = WAIT_VS;
    endcase
  end

  assign tracked = (state != WAIT_VS);
  assign px      = (state == LINE) ? x : 16'd0;
  assign border  = (px < 16'd2) || (y < 16'd2);
  assign hit     = (in_data >= sh_thresh);

  always_comb begin
    proc_data = '0;
    if (!sh_en || !tracked) begin
      proc_data = in_data;
    end else if (border) begin
      proc_data = '0;
    end else if (hit) begin
      proc_data = sh_binary ? {BITS{1'b1}} : in_data;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_VS;
      x          <= 16'd0;
      y          <= 16'd0;
      vs_prev    <= 1'b1;
      href_prev  <= 1'b0;
      out_href   <= 1'b0;
      out_vsync  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
      err_geom   <= 1'b0;
    end else begin
      state      <= state_nxt;
      x          <= x_nxt;
      y          <= y_nxt;
      vs_prev    <= in_vsync;
      href_prev  <= in_href;
      out_href   <= in_href;
      out_vsync  <= in_vsync;
      out_data   <= in_href ? proc_data : '0;
      frame_done <= frame_end;
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
      if (err_set) begin
        err_geom <= 1'b1;
      end else if (cfg_apply) begin
        err_geom <= 1'b0;
      end
    end
  end

  // shadow only moves on a vsync rise, so a frame always sees one configuration
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sh_en      <= 1'b0;
      sh_thresh  <= '0;
      sh_binary  <= 1'b0;
      stg_en     <= 1'b0;
      stg_thresh <= '0;
      stg_binary <= 1'b0;
      pending    <= 1'b0;
    end else if (vs_rise && cfg_apply) begin
      sh_en      <= cfg_en;
      sh_thresh  <= cfg_thresh;
      sh_binary  <= cfg_binary;
      pending    <= 1'b0;
    end else if (vs_rise && pending) begin
      sh_en      <= stg_en;
      sh_thresh  <= stg_thresh;
      sh_binary  <= stg_binary;
      pending    <= 1'b0;
    end else if (cfg_apply) begin
      stg_en     <= cfg_en;
      stg_thresh <= cfg_thresh;
      stg_binary <= cfg_binary;
      pending    <= 1'b1;
    end
  end

`ifdef VIP_SOBEL_CTRL_STATS_EN
  logic [31:0] stat_cnt, stat_nxt;
  logic        edge_inc;

  assign edge_inc = in_href && tracked && sh_en && !border && hit;
  assign stat_nxt = (edge_inc && (stat_cnt != 32'hFFFF_FFFF)) ? stat_cnt + 32'd1 : stat_cnt;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt <= 32'd0;
      edge_cnt <= 32'd0;
    end else if (frame_end) begin
      edge_cnt <= stat_nxt;
      stat_cnt <= 32'd0;
    end else begin
      stat_cnt <= stat_nxt;
    end
  end
`else
  assign edge_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_vip_sobel_ctrl.sv
// tb/tb_vip_sobel_ctrl.sv - self-checking bench for vip_sobel_ctrl on a small frame geometry.
module tb_vip_sobel_ctrl;

  localparam int BITS = 8;
  localparam int W    = 8;
  localparam int H    = 6;

  logic            pclk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_en = 1'b0;
  logic [BITS-1:0] cfg_thresh = '0;
  logic            cfg_binary = 1'b0;
  logic            cfg_apply = 1'b0;
  logic            in_href = 1'b0;
  logic            in_vsync = 1'b0;
  logic [BITS-1:0] in_data = '0;
  logic            out_href, out_vsync, frame_done, err_geom;
  logic [BITS-1:0] out_data;
  logic [15:0]     frame_cnt;
  logic [31:0]     edge_cnt;

  always #5 pclk = ~pclk;

  vip_sobel_ctrl #(.BITS(BITS), .WIDTH(W), .HEIGHT(H)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .cfg_en(cfg_en), .cfg_thresh(cfg_thresh), .cfg_binary(cfg_binary), .cfg_apply(cfg_apply),
    .in_href(in_href), .in_vsync(in_vsync), .in_data(in_data),
    .out_href(out_href), .out_vsync(out_vsync), .out_data(out_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .err_geom(err_geom), .edge_cnt(edge_cnt)
  );

  typedef struct {
    bit         en;
    logic [7:0] thr;
    bit         bin;
    int         r;
    int         c;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  int tests = 0;
  int fails = 0;
  int fd_seen = 0;
  int lat_bad = 0;

  logic [7:0] img [0:H+1][0:W-1];
  logic [7:0] cap [0:H+1][0:W-1];

  // frame-level model of the configuration pipeline and status
  bit         s_en, s_bin, p_en, p_bin, pend, m_err;
  logic [7:0] s_thr, p_thr;
  int         m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_pix(bit en, logic [7:0] thr, bit bin, int r, int c, logic [7:0] d);
    if (!en) return d;
    if (r < 2 || c < 2) return 8'h00;
    if (d >= thr) return bin ? 8'hFF : d;
    return 8'h00;
  endfunction

  task automatic step(input logic h, input logic v, input logic [7:0] d, input logic ap, output logic [7:0] o);
    in_href = h; in_vsync = v; in_data = d; cfg_apply = ap;
    @(posedge pclk); #1;
    o = out_data;
    if (out_href !== h || out_vsync !== v || (!h && out_data !== 8'h00)) lat_bad++;
    if (frame_done === 1'b1) fd_seen++;
  endtask

  task automatic fill_img();
    for (int r = 0; r < H + 2; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 8'($urandom);
  endtask

  task automatic apply_idle();
    logic [7:0] o;
    step(1'b0, 1'b0, 8'h00, 1'b1, o);
    p_en = cfg_en; p_thr = cfg_thresh; p_bin = cfg_binary; pend = 1; m_err = 0;
    step(1'b0, 1'b0, 8'h00, 1'b0, o);
  endtask

  // apply_when: 0 none, 1 together with the vsync rise, 2 mid-frame
  task automatic run_frame(input int nl, input int short_row, input int apply_when, input string tag);
    logic [7:0] o, e;
    int fd0, lat0, bad, ec, len;
    bit f_en, f_bin;
    logic [7:0] f_thr;
    bit ap;
    fd0 = fd_seen; lat0 = lat_bad;
    step(1'b0, 1'b0, 8'h00, 1'b0, o);
    step(1'b0, 1'b0, 8'h00, 1'b0, o);
    if (apply_when == 1) begin
      s_en = cfg_en; s_thr = cfg_thresh; s_bin = cfg_binary; pend = 0; m_err = 0;
    end else if (pend) begin
      s_en = p_en; s_thr = p_thr; s_bin = p_bin; pend = 0;
    end
    f_en = s_en; f_thr = s_thr; f_bin = s_bin;
    step(1'b0, 1'b1, 8'h00, apply_when == 1, o);
    step(1'b0, 1'b1, 8'h00, 1'b0, o);
    for (int r = 0; r < nl; r++) begin
      len = (r == short_row) ? W - 1 : W;
      for (int c = 0; c < len; c++) begin
        ap = (apply_when == 2 && r == 2 && c == 3);
        step(1'b1, 1'b1, img[r][c], ap, o);
        cap[r][c] = o;
        if (ap) begin
          p_en = cfg_en; p_thr = cfg_thresh; p_bin = cfg_binary; pend = 1; m_err = 0;
        end
      end
      step(1'b0, 1'b1, 8'h00, 1'b0, o);
      if (r == short_row) begin
        m_err = 1;
        check($sformatf("%s err_at_href_fall", tag), err_geom, 1);
      end
      step(1'b0, 1'b1, 8'h00, 1'b0, o);
    end
    if (nl != H) m_err = 1;
    step(1'b0, 1'b0, 8'h00, 1'b0, o);
    check($sformatf("%s frame_done_aligned", tag), frame_done, 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, o);
    m_cnt = (m_cnt + 1) & 16'hFFFF;
    bad = 0; ec = 0;
    for (int r = 0; r < nl; r++) begin
      len = (r == short_row) ? W - 1 : W;
      for (int c = 0; c < len; c++) begin
        e = exp_pix(f_en, f_thr, f_bin, r, c, img[r][c]);
        if (cap[r][c] !== e) begin
          if (bad == 0) $display("  %s first bad pixel r%0d c%0d in %0h got %0h want %0h", tag, r, c, img[r][c], cap[r][c], e);
          bad++;
        end
        if (f_en && r >= 2 && c >= 2 && img[r][c] >= f_thr) ec++;
      end
    end
    check($sformatf("%s bad_pixel_count", tag), bad, 0);
    check($sformatf("%s frame_done_pulses", tag), fd_seen - fd0, 1);
    check($sformatf("%s frame_cnt", tag), frame_cnt, m_cnt);
    check($sformatf("%s err_geom", tag), err_geom, m_err);
    check($sformatf("%s sync_latency_errors", tag), lat_bad - lat0, 0);
`ifdef VIP_SOBEL_CTRL_STATS_EN
    check($sformatf("%s edge_cnt", tag), edge_cnt, ec);
`else
    check($sformatf("%s edge_cnt", tag), edge_cnt, 0);
`endif
  endtask

  initial begin
    logic [7:0] o, d;
    int bad, fd0, mode;

    vecs[0]  = '{1'b0, 8'h80, 1'b1, 3, 3, 8'h10, 8'h10};
    vecs[1]  = '{1'b1, 8'h80, 1'b1, 3, 3, 8'h80, 8'hFF};
    vecs[2]  = '{1'b1, 8'h80, 1'b1, 3, 3, 8'h7F, 8'h00};
    vecs[3]  = '{1'b1, 8'h80, 1'b0, 4, 5, 8'hC3, 8'hC3};
    vecs[4]  = '{1'b1, 8'h80, 1'b0, 4, 5, 8'h7F, 8'h00};
    vecs[5]  = '{1'b1, 8'h00, 1'b0, 2, 2, 8'h05, 8'h05};
    vecs[6]  = '{1'b1, 8'h00, 1'b0, 1, 4, 8'h55, 8'h00};
    vecs[7]  = '{1'b1, 8'h00, 1'b1, 5, 1, 8'h55, 8'h00};
    vecs[8]  = '{1'b1, 8'h00, 1'b1, 2, 2, 8'h00, 8'hFF};
    vecs[9]  = '{1'b1, 8'hFF, 1'b1, 5, 7, 8'hFF, 8'hFF};
    vecs[10] = '{1'b1, 8'hFF, 1'b0, 5, 7, 8'hFE, 8'h00};
    vecs[11] = '{1'b1, 8'h10, 1'b0, 0, 0, 8'hFF, 8'h00};

    s_en = 0; s_thr = 0; s_bin = 0; p_en = 0; p_thr = 0; p_bin = 0; pend = 0; m_err = 0; m_cnt = 0;

    // reset with vsync already high, then an untracked partial frame
    in_vsync = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_outputs", {out_href, out_vsync, out_data, frame_done, frame_cnt, err_geom, edge_cnt}, 0);
    rst_n = 1'b1;
    bad = 0; fd0 = fd_seen;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        d = 8'($urandom);
        step(1'b1, 1'b1, d, 1'b0, o);
        if (o !== d) bad++;
      end
      step(1'b0, 1'b1, 8'h00, 1'b0, o);
      step(1'b0, 1'b1, 8'h00, 1'b0, o);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, o);
    step(1'b0, 1'b0, 8'h00, 1'b0, o);
    check("partial_passthru_bad", bad, 0);
    check("partial_no_done", fd_seen - fd0, 0);
    check("partial_frame_cnt", frame_cnt, 0);
    check("partial_err", err_geom, 0);

    fill_img();
    run_frame(H, -1, 0, "first_full");

    // mid-frame apply takes effect only on the following frame
    cfg_en = 1'b1; cfg_thresh = 8'h40; cfg_binary = 1'b1;
    fill_img();
    run_frame(H, -1, 2, "mid_apply");
    fill_img();
    img[3][3] = 8'h3F; img[3][4] = 8'h40; img[0][5] = 8'hFF; img[4][1] = 8'hFF;
    run_frame(H, -1, 0, "after_mid");
    check("thr40_below", cap[3][3], 8'h00);
    check("thr40_equal", cap[3][4], 8'hFF);
    check("row_border", cap[0][5], 8'h00);
    check("col_border", cap[4][1], 8'h00);

    // apply coincident with vsync rise is used by that same frame
    cfg_en = 1'b1; cfg_thresh = 8'h10; cfg_binary = 1'b0;
    fill_img();
    img[3][3] = 8'h20; img[3][4] = 8'h0F;
    run_frame(H, -1, 1, "rise_apply");
    check("thr10_above", cap[3][3], 8'h20);
    check("thr10_below", cap[3][4], 8'h00);

    for (int i = 0; i < 12; i++) begin
      cfg_en = vecs[i].en; cfg_thresh = vecs[i].thr; cfg_binary = vecs[i].bin;
      apply_idle();
      fill_img();
      img[vecs[i].r][vecs[i].c] = vecs[i].d;
      run_frame(H, -1, 0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d pixel", i), cap[vecs[i].r][vecs[i].c], vecs[i].exp);
    end

    for (int k = 0; k < 8; k++) begin
      cfg_en = 1'($urandom_range(0, 1)); cfg_thresh = 8'($urandom); cfg_binary = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      if (mode == 0) apply_idle();
      fill_img();
      run_frame(H, -1, (mode == 0) ? 0 : mode, $sformatf("rand%0d", k));
    end

    // geometry errors: short line, sticky, clear, too many lines
    apply_idle();
    check("err_clear_pre", err_geom, 0);
    fill_img();
    run_frame(H, 2, 0, "short_line");
    fill_img();
    run_frame(H, -1, 0, "sticky");
    apply_idle();
    check("err_clear_after_short", err_geom, 0);
    fill_img();
    run_frame(H + 1, -1, 0, "tall_frame");
    apply_idle();
    check("err_clear_after_tall", err_geom, 0);

    // asynchronous reset in the middle of a line
    step(1'b0, 1'b0, 8'h00, 1'b0, o);
    step(1'b0, 1'b1, 8'h00, 1'b0, o);
    step(1'b0, 1'b1, 8'h00, 1'b0, o);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 8'hAA, 1'b0, o);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {out_href, out_vsync, out_data, frame_done, frame_cnt, err_geom, edge_cnt}, 0);
    in_href = 1'b0; in_vsync = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge pclk);
    #1;
    rst_n = 1'b1;
    s_en = 0; s_thr = 0; s_bin = 0; pend = 0; m_err = 0; m_cnt = 0;
    fill_img();
    run_frame(H, -1, 0, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
